// File: rtl/m_axis_rc_adapt_gen_pkg.sv
// Shared definitions for the RC completion adapter: descriptor field map,
// completion fmt/type codes and small helper functions.
package pcie_rc_pkg;

  localparam int LOWADDR_LSB = 0;
  localparam int BYTECNT_LSB = 16;
  localparam int LOCKED_BIT  = 29;
  localparam int DWLEN_LSB   = 32;
  localparam int STATUS_LSB  = 43;
  localparam int POISON_BIT  = 46;
  localparam int REQID_LSB   = 48;
  localparam int TAG_LSB     = 64;
  localparam int CPLID_LSB   = 72;
  localparam int TC_LSB      = 89;
  localparam int ATTR_LSB    = 92;
  localparam int DW3_LSB     = 96;

  localparam logic [7:0] FT_CPL      = 8'b010_01010;
  localparam logic [7:0] FT_CPL_ND   = 8'b000_01010;
  localparam logic [7:0] FT_CPLLK    = 8'b010_01011;
  localparam logic [7:0] FT_CPLLK_ND = 8'b000_01011;

  localparam int KEEP_MAX = 16;

  typedef struct packed {
    logic [31:0] dw3;
    logic [1:0]  attr;
    logic [2:0]  tc;
    logic [15:0] cpl_id;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic        poison;
    logic [2:0]  status;
    logic [9:0]  dwlen;
    logic        locked;
    logic [11:0] bytecnt;
    logic [6:0]  lowaddr;
  } rc_desc_t;

  function automatic int disc_bit_for(input int dw);
    return (dw == 512) ? 96 : 42;
  endfunction

  function automatic int user_width_for(input int dw);
    return (dw == 512) ? 161 : 75;
  endfunction

  function automatic logic [4*KEEP_MAX-1:0] keep_expand(input logic [KEEP_MAX-1:0] k);
    logic [4*KEEP_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      r[4*i +: 4] = {4{k[i]}};
    end
    return r;
  endfunction

  function automatic rc_desc_t desc_decode(input logic [127:0] d);
    rc_desc_t f;
    f.lowaddr = d[LOWADDR_LSB +: 7];
    f.bytecnt = d[BYTECNT_LSB +: 12];
    f.locked  = d[LOCKED_BIT];
    f.dwlen   = d[DWLEN_LSB +: 10];
    f.status  = d[STATUS_LSB +: 3];
    f.poison  = d[POISON_BIT];
    f.req_id  = d[REQID_LSB +: 16];
    f.tag     = d[TAG_LSB +: 8];
    f.cpl_id  = d[CPLID_LSB +: 16];
    f.tc      = d[TC_LSB +: 3];
    f.attr    = d[ATTR_LSB +: 2];
    f.dw3     = d[DW3_LSB +: 32];
    return f;
  endfunction

  // Returns {hdr1, hdr0} of the legacy 3-DW completion header.
  function automatic logic [127:0] hdr_build(input rc_desc_t f);
    logic [7:0]  ft;
    logic [63:0] hdr0;
    logic [63:0] hdr1;
    if (f.locked) begin
      ft = (f.bytecnt == 12'd0) ? FT_CPLLK_ND : FT_CPLLK;
    end else begin
      ft = (f.bytecnt == 12'd0) ? FT_CPL_ND : FT_CPL;
    end
    hdr0 = {f.cpl_id, f.status, 1'b0, f.bytecnt, ft, 1'b0, f.tc, 4'b0000,
            1'b0, f.poison, f.attr, 2'b00, f.dwlen};
    hdr1 = {f.dw3, f.req_id, f.tag, 1'b0, f.lowaddr};
    return {hdr1, hdr0};
  endfunction

endpackage

// File: rtl/m_axis_rc_adapt_gen_if.sv
// AXI-stream style bundle used for the completion path and its skid buffer.
interface rc_stream_if #(
  parameter int DW = 256,
  parameter int KW = 32,
  parameter int UW = 2
) ();
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic          tlast;
  logic [UW-1:0] tuser;
  logic          tvalid;
  logic          tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/m_axis_rc_adapt_gen_skid.sv
// Two-entry skid buffer (output register + skid register) with a registered
// ready, so both directions of the stream are cut by flops.
module axis_skid_buffer #(
  parameter int DW = 256,
  parameter int KW = 32,
  parameter int UW = 2
) (
  input logic           clk,
  input logic           srst,
  rc_stream_if.slave    s,
  rc_stream_if.master   m
);
  localparam int PW = DW + KW + 1 + UW;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl_q, out_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          out_valid_q, out_valid_d;
  logic          skid_valid_q, skid_valid_d;
  logic          ready_q, ready_d;
  logic          in_xfer;

  assign in_pl    = {s.tdata, s.tkeep, s.tlast, s.tuser};
  assign in_xfer  = s.tvalid & ready_q;
  assign s.tready = ready_q;
  assign m.tvalid = out_valid_q;
  assign {m.tdata, m.tkeep, m.tlast, m.tuser} = out_pl_q;

  always_comb begin
    out_pl_d     = out_pl_q;
    out_valid_d  = out_valid_q;
    skid_pl_d    = skid_pl_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m.tready) begin
      // Output register drains this cycle; refill from skid first to keep order.
      if (skid_valid_q) begin
        out_pl_d     = skid_pl_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_xfer;
        if (in_xfer) begin
          out_pl_d = in_pl;
        end
      end
    end else if (in_xfer) begin
      skid_pl_d    = in_pl;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    out_pl_q  <= out_pl_d;
    skid_pl_q <= skid_pl_d;
    if (srst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: rtl/m_axis_rc_adapt_gen.sv
// RC completion adapter: rewrites hard-IP RC descriptors into legacy 3-DW
// completion headers, adds error sideband and saturating statistics.
module m_axis_rc_adapt_gen
  import pcie_rc_pkg::*;
#(
  parameter int DATA_WIDTH    = 256,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 32,
  parameter int USER_WIDTH_IN = user_width_for(DATA_WIDTH),
  parameter int DISC_BIT      = disc_bit_for(DATA_WIDTH),
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     user_clk,
  input  logic                     user_reset,
  input  logic [DATA_WIDTH-1:0]    s_axis_rc_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_rc_tkeep,
  input  logic                     s_axis_rc_tlast,
  input  logic [USER_WIDTH_IN-1:0] s_axis_rc_tuser,
  input  logic                     s_axis_rc_tvalid,
  output logic                     s_axis_rc_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_rc_tdata,
  output logic [DATA_WIDTH/8-1:0]  m_axis_rc_tkeep,
  output logic                     m_axis_rc_tlast,
  output logic [1:0]               m_axis_rc_tuser,
  output logic                     m_axis_rc_tvalid,
  input  logic                     m_axis_rc_tready,
  output logic [CNT_WIDTH-1:0]     cpl_count,
  output logic [CNT_WIDTH-1:0]     poison_count
);
  localparam int BYTE_W = DATA_WIDTH / 8;

  rc_stream_if #(.DW(DATA_WIDTH), .KW(BYTE_W), .UW(2)) skid_in ();
  rc_stream_if #(.DW(DATA_WIDTH), .KW(BYTE_W), .UW(2)) skid_out ();

  logic                  in_pkt_q, in_pkt_d;
  logic                  poison_lat_q, poison_lat_d;
  logic [CNT_WIDTH-1:0]  cpl_count_q, cpl_count_d;
  logic [CNT_WIDTH-1:0]  poison_count_q, poison_count_d;
  rc_desc_t              desc;
  logic [127:0]          hdr;
  logic [4*KEEP_MAX-1:0] keep_full;
  logic                  sop;
  logic                  in_xfer;
  logic                  out_xfer;
  logic                  err_fwd;
  logic                  unused_bits;

  assign sop       = !in_pkt_q;
  assign in_xfer   = s_axis_rc_tvalid & skid_in.tready;
  assign out_xfer  = skid_out.tvalid & m_axis_rc_tready;
  assign desc      = desc_decode(s_axis_rc_tdata[127:0]);
  assign hdr       = hdr_build(desc);
  assign keep_full = keep_expand(KEEP_MAX'(s_axis_rc_tkeep));
  // Poison is only carried in the SOP descriptor; later beats reuse the latched copy.
  assign err_fwd   = sop ? desc.poison : poison_lat_q;

  assign unused_bits = ^{s_axis_rc_tuser, keep_full};

  always_comb begin
    skid_in.tvalid = s_axis_rc_tvalid;
    skid_in.tlast  = s_axis_rc_tlast;
    skid_in.tuser  = {s_axis_rc_tuser[DISC_BIT], err_fwd};
    skid_in.tdata  = s_axis_rc_tdata;
    skid_in.tkeep  = keep_full[BYTE_W-1:0];
    if (sop) begin
      skid_in.tdata[127:0] = hdr;
      skid_in.tkeep[11:0]  = '1;
    end
  end

  assign s_axis_rc_tready = skid_in.tready;

  axis_skid_buffer #(.DW(DATA_WIDTH), .KW(BYTE_W), .UW(2)) u_skid (
    .clk  (user_clk),
    .srst (user_reset),
    .s    (skid_in),
    .m    (skid_out)
  );

  assign skid_out.tready  = m_axis_rc_tready;
  assign m_axis_rc_tdata  = skid_out.tdata;
  assign m_axis_rc_tkeep  = skid_out.tkeep;
  assign m_axis_rc_tlast  = skid_out.tlast;
  assign m_axis_rc_tuser  = skid_out.tuser;
  assign m_axis_rc_tvalid = skid_out.tvalid;

  always_comb begin
    in_pkt_d       = in_pkt_q;
    poison_lat_d   = poison_lat_q;
    cpl_count_d    = cpl_count_q;
    poison_count_d = poison_count_q;
    if (in_xfer) begin
      in_pkt_d = !s_axis_rc_tlast;
      if (sop) begin
        poison_lat_d = desc.poison;
      end
    end
    if (out_xfer && skid_out.tlast) begin
      if (cpl_count_q != '1) begin
        cpl_count_d = cpl_count_q + CNT_WIDTH'(1);
      end
      if (skid_out.tuser[0] && poison_count_q != '1) begin
        poison_count_d = poison_count_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      in_pkt_q       <= 1'b0;
      poison_lat_q   <= 1'b0;
      cpl_count_q    <= '0;
      poison_count_q <= '0;
    end else begin
      in_pkt_q       <= in_pkt_d;
      poison_lat_q   <= poison_lat_d;
      cpl_count_q    <= cpl_count_d;
      poison_count_q <= poison_count_d;
    end
  end

  assign cpl_count    = cpl_count_q;
  assign poison_count = poison_count_q;

endmodule
